tdc_event_reader: RTL

- Consumer-side controller for the TDC channel interface: detects o_hasEvent from a TDC channel, captures timestamp and pulse width, and issues the clear to re-arm the channel.
- Each captured event is stored as a 64-bit record in an internal FIFO and drained downstream through a valid/ready port.
- Counts events dropped on FIFO overflow and flags channels that fail to release hasEvent after a clear.
- Sits between TDC_dumb-class channels and the readout/serializer logic.

---
 rtl/tdc_event_reader_if.sv | 22 ++
 rtl/tdc_event_reader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tdc_event_reader_if.sv
// TDC channel handshake plus downstream record stream, as seen by the event reader.
// master = reader side, slave = channel/readout side.
interface tdc_event_reader_if;
    logic        i_hasEvent;
    logic        i_busy;
    logic [31:0] i_timestamp;
    logic [31:0] i_pulseWidth;
    logic        o_clear;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready;

    modport master (
        input  i_hasEvent, i_busy, i_timestamp, i_pulseWidth, i_ready,
        output o_clear, o_data, o_valid
    );

    modport slave (
        output i_hasEvent, i_busy, i_timestamp, i_pulseWidth, i_ready,
        input  o_clear, o_data, o_valid
    );
endinterface

// File: rtl/tdc_event_reader.sv
// Captures TDC channel events into a first-word-fall-through record FIFO, re-arms
// the channel with a clear pulse, and watches for channels that never release hasEvent.
module tdc_event_reader #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CLEAR_TIMEOUT = 16,
    parameter int unsigned DROP_CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_enable,
    output logic                        o_enable_channel,
    tdc_event_reader_if.master          bus,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic [DROP_CNT_W-1:0]       o_drop_count,
    output logic                        o_error
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLEAR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CLEAR,
        WAIT_REL
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
    logic            clear_n, timeout, clear_q;

    logic [63:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, push, pop, drop;

    // tmo_cnt holds cycles since the most recent clear pulse (0 on the pulse cycle)
    always_comb begin
        state_n   = state;
        tmo_cnt_n = tmo_cnt;
        clear_n   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable && bus.i_hasEvent) state_n = CAPTURE;
            end
            CAPTURE: begin
                state_n   = CLEAR;
                clear_n   = 1'b1;
                tmo_cnt_n = '0;
            end
            CLEAR: begin
                state_n   = WAIT_REL;
                tmo_cnt_n = tmo_cnt + 1'b1;
            end
            WAIT_REL: begin
                if (!bus.i_hasEvent) begin
                    state_n = IDLE;
                end else if (tmo_cnt == TW'(CLEAR_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    clear_n   = 1'b1;
                    tmo_cnt_n = '0;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            clear_q          <= 1'b0;
            o_error          <= 1'b0;
            o_enable_channel <= 1'b0;
            o_drop_count     <= '0;
        end else begin
            state            <= state_n;
            tmo_cnt          <= tmo_cnt_n;
            clear_q          <= clear_n;
            o_enable_channel <= i_enable;
            if (timeout) o_error <= 1'b1;
            if (drop && (o_drop_count != '1)) o_drop_count <= o_drop_count + 1'b1;
        end
    end

    // A pop in the capture cycle frees the slot the push needs, so a full FIFO does not drop
    assign full = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop  = bus.o_valid && bus.i_ready;
    assign push = (state == CAPTURE) && (!full || pop);
    assign drop = (state == CAPTURE) && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.i_timestamp, bus.i_pulseWidth};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.o_clear   = clear_q;
    assign bus.o_valid   = (count != '0);
    assign bus.o_data    = mem[rd_ptr];
    assign o_fifo_count  = count;

    // A channel reporting a finished event cannot still be measuring
    assert property (@(posedge clk) disable iff (reset) !(bus.i_hasEvent && bus.i_busy));
endmodule
